// File: rtl/sram_port0_ctrl.sv
// Port 0 (RW) front end for the 32x256 OpenRAM macro: registered pin drive,
// read-data capture and a credit-limited read-response FIFO.
module sram_port0_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WMASKS = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  logic                  accept;
  logic                  rd_accept;
  logic                  push;
  logic                  pop;
  logic                  rd_s1;
  logic [CNT_W-1:0]      outs;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  // Credit covers stage 0, stage 1 and the FIFO, so the FIFO can never overflow.
  assign req_ready = (outs < DEPTH_C);
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_we;
  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_rdata = fifo_mem[rd_ptr];
  assign pop       = rsp_valid && rsp_ready;
  assign push      = rd_s1;

  // Stage 0: macro pins, strictly register outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csb0   <= 1'b1;
      web0   <= 1'b1;
      wmask0 <= '0;
      addr0  <= '0;
      din0   <= '0;
    end else if (accept) begin
      csb0  <= 1'b0;
      web0  <= ~req_we;
      addr0 <= req_addr;
      if (req_we) begin
        wmask0 <= req_wmask;
        din0   <= req_wdata;
      end else begin
        wmask0 <= '0;
      end
    end else begin
      csb0 <= 1'b1;
      web0 <= 1'b1;
    end
  end

  // Stage 1: the macro samples the pins on this edge; dout0 is captured one edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_s1 <= 1'b0;
    end else begin
      rd_s1 <= ~csb0 & web0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outs <= '0;
    end else if (rd_accept && !pop) begin
      outs <= outs + 1'b1;
    end else if (!rd_accept && pop) begin
      outs <= outs - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= dout0;
        wr_ptr           <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + 1'b1;
      end else if (!push && pop) begin
        fifo_cnt <= fifo_cnt - 1'b1;
      end
    end
  end

endmodule
